// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs two-word immediate instructions
// into one packet and injects interrupt CALL packets ahead of normal fetch.
module fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_interrupt,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    input  logic [15:0]         i_imem_data,
    output logic [15:0]         o_instr,
    output logic [15:0]         o_imm,
    output logic [PC_WIDTH-1:0] o_pc_next,
    output logic                o_valid,
    output logic                o_interrupt,
    output logic [1:0]          o_state
);

    localparam logic [1:0] FETCH     = 2'd0;
    localparam logic [1:0] FETCH_IMM = 2'd1;
    localparam logic [1:0] INT_HOLD  = 2'd2;

    localparam logic [15:0] CALL_WORD = {5'b00101, 11'b0};

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [1:0]          state;
    logic                pending;
    logic [15:0]         held;
    logic [4:0]          opcode;
    logic                two_word;

    assign pc_inc      = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign opcode      = i_imem_data[15:11];
    assign two_word    = (opcode == 5'b10010) || (opcode == 5'b11110) || (opcode == 5'b11111);
    assign o_imem_addr = pc;
    assign o_state     = state;

    // o_pc_next keeps its last value on bubbles; only valid packets carry a return address.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            pending     <= 1'b0;
            held        <= 16'h0;
            o_instr     <= 16'h0;
            o_imm       <= 16'h0;
            o_pc_next   <= '0;
            o_valid     <= 1'b0;
            o_interrupt <= 1'b0;
        end else begin
            pending <= pending | i_interrupt;
            if (i_branch_taken) begin
                pc          <= i_branch_target;
                state       <= FETCH;
                held        <= 16'h0;
                o_instr     <= 16'h0;
                o_imm       <= 16'h0;
                o_valid     <= 1'b0;
                o_interrupt <= 1'b0;
            end else if (!i_stall) begin
                case (state)
                    FETCH: begin
                        if (pending) begin
                            // A request arriving on the injection cycle merges into this CALL.
                            pending     <= 1'b0;
                            state       <= INT_HOLD;
                            o_instr     <= CALL_WORD;
                            o_imm       <= 16'h0;
                            o_pc_next   <= pc;
                            o_valid     <= 1'b1;
                            o_interrupt <= 1'b1;
                        end else if (two_word) begin
                            held        <= i_imem_data;
                            pc          <= pc_inc;
                            state       <= FETCH_IMM;
                            o_instr     <= 16'h0;
                            o_imm       <= 16'h0;
                            o_valid     <= 1'b0;
                            o_interrupt <= 1'b0;
                        end else begin
                            pc          <= pc_inc;
                            o_instr     <= i_imem_data;
                            o_imm       <= 16'h0;
                            o_pc_next   <= pc_inc;
                            o_valid     <= 1'b1;
                            o_interrupt <= 1'b0;
                        end
                    end
                    FETCH_IMM: begin
                        pc          <= pc_inc;
                        state       <= FETCH;
                        o_instr     <= held;
                        o_imm       <= i_imem_data;
                        o_pc_next   <= pc_inc;
                        o_valid     <= 1'b1;
                        o_interrupt <= 1'b0;
                    end
                    default: begin
                        // INT_HOLD waits for the ISR redirect; unused encodings fall back to FETCH.
                        if (state != INT_HOLD) begin
                            state <= FETCH;
                        end
                        o_instr     <= 16'h0;
                        o_imm       <= 16'h0;
                        o_valid     <= 1'b0;
                        o_interrupt <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/branch/interrupt
// traffic, each cycle compared against a packet-level reference model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        interrupt;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc_next;
    logic        valid;
    logic        intr_out;
    logic [1:0]  state_dbg;

    logic [15:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: fetch address, interrupt latch, half-assembled packet, ISR wait
    logic [31:0] m_pc;
    bit          m_pending;
    bit          m_have_first;
    bit          m_in_isr;
    logic [15:0] m_first;
    bit          e_valid;
    bit          e_int;
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic [31:0] e_pc_next;

    assign imem_data = mem[imem_addr[9:0]];

    fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_interrupt     (interrupt),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .o_instr         (instr),
        .o_imm           (imm),
        .o_pc_next       (pc_next),
        .o_valid         (valid),
        .o_interrupt     (intr_out),
        .o_state         (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_two_word(input logic [15:0] w);
        return w[15:11] inside {5'd18, 5'd30, 5'd31};
    endfunction

    task automatic model_cycle(input bit rst, input bit stl, input bit br,
                               input logic [31:0] tgt, input bit irq);
        logic [15:0] w;
        w = mem[m_pc[9:0]];
        if (rst) begin
            m_pc = 32'h0; m_pending = 0; m_have_first = 0; m_in_isr = 0; m_first = 16'h0;
            e_valid = 0; e_int = 0; e_instr = 16'h0; e_imm = 16'h0; e_pc_next = 32'h0;
        end else if (br) begin
            m_pending = m_pending | irq;
            m_pc = tgt; m_have_first = 0; m_in_isr = 0;
            e_valid = 0; e_int = 0; e_instr = 16'h0; e_imm = 16'h0;
        end else if (stl) begin
            m_pending = m_pending | irq;
        end else if (m_have_first) begin
            m_pending = m_pending | irq;
            e_valid = 1; e_int = 0; e_instr = m_first; e_imm = w;
            m_pc = m_pc + 1; e_pc_next = m_pc; m_have_first = 0;
        end else if (m_in_isr) begin
            m_pending = m_pending | irq;
            e_valid = 0; e_int = 0; e_instr = 16'h0; e_imm = 16'h0;
        end else if (m_pending) begin
            m_pending = 0; m_in_isr = 1;
            e_valid = 1; e_int = 1; e_instr = 16'h2800; e_imm = 16'h0; e_pc_next = m_pc;
        end else if (is_two_word(w)) begin
            m_pending = m_pending | irq;
            m_first = w; m_have_first = 1; m_pc = m_pc + 1;
            e_valid = 0; e_int = 0; e_instr = 16'h0; e_imm = 16'h0;
        end else begin
            m_pending = m_pending | irq;
            e_valid = 1; e_int = 0; e_instr = w; e_imm = 16'h0;
            m_pc = m_pc + 1; e_pc_next = m_pc;
        end
    endtask

    task automatic compare_outputs();
        check_eq("valid", {31'b0, valid}, {31'b0, e_valid});
        check_eq("interrupt", {31'b0, intr_out}, {31'b0, e_int});
        check_eq("instr", {16'b0, instr}, {16'b0, e_instr});
        check_eq("imm", {16'b0, imm}, {16'b0, e_imm});
        check_eq("imem_addr", imem_addr, m_pc);
        if (e_valid) check_eq("pc_next", pc_next, e_pc_next);
    endtask

    // inputs change at the falling edge; outputs are sampled at the next falling edge
    task automatic step(input bit rst, input bit stl, input bit br,
                        input logic [31:0] tgt, input bit irq);
        reset = rst; stall = stl; branch_taken = br; branch_target = tgt; interrupt = irq;
        model_cycle(rst, stl, br, tgt, irq);
        @(posedge clk);
        @(negedge clk);
        reset = 0; stall = 0; branch_taken = 0; branch_target = 32'h0; interrupt = 0;
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h5000; mem[1] = 16'h0000; mem[2] = 16'h4800; mem[3] = 16'h6000;
        mem[4] = 16'h9040; mem[5] = 16'h1234;
        mem[12'h020] = 16'h5800; mem[12'h030] = 16'h0800;
        mem[12'h100] = 16'h5000; mem[12'h101] = 16'h3000;
        mem[1023] = 16'h4000;

        reset = 1; stall = 0; branch_taken = 0; branch_target = 32'h0; interrupt = 0;
        @(negedge clk);
        step(1, 0, 0, 32'h0, 0);
        check_eq("reset_pc_next", pc_next, 32'h0);

        // straight-line single-word code
        step(0, 0, 0, 32'h0, 0);
        check_eq("add_instr", {16'b0, instr}, 32'h5000);
        check_eq("add_pc_next", pc_next, 32'h1);
        run(3);
        // LDM pair: bubble then assembled packet
        step(0, 0, 0, 32'h0, 0);
        check_eq("ldm_bubble", {31'b0, valid}, 32'h0);
        step(0, 0, 0, 32'h0, 0);
        check_eq("ldm_imm", {16'b0, imm}, 32'h1234);
        check_eq("ldm_pc_next", pc_next, 32'h6);

        // interrupt during second word: CALL follows the LDM packet
        step(0, 0, 1, 32'h4, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);
        check_eq("ldm_before_call", {16'b0, instr}, 32'h9040);
        step(0, 0, 0, 32'h0, 0);
        check_eq("call_instr", {16'b0, instr}, 32'h2800);
        check_eq("call_ret", pc_next, 32'h6);
        run(3);
        step(0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 32'h0, 0);
        check_eq("isr_first", {16'b0, instr}, 32'h5000);

        // redirect while holding the first word
        step(0, 0, 1, 32'h4, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h20, 0);
        step(0, 0, 0, 32'h0, 0);
        check_eq("after_flush", {16'b0, instr}, 32'h5800);

        // stall freezes everything; interrupt during the stall is injected afterwards
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        check_eq("stall_call", {31'b0, intr_out}, 32'h1);
        step(0, 0, 1, 32'h30, 0);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFF, 0);
        step(0, 0, 0, 32'h0, 0);
        check_eq("wrap_pc_next", pc_next, 32'h0);

        // reset in the middle of a two-word fetch
        step(0, 0, 1, 32'h4, 0);
        step(0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        check_eq("mid_reset_pc_next", pc_next, 32'h0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            bit rst, stl, br, irq;
            logic [31:0] tgt;
            rst = ($urandom_range(0, 199) == 0);
            stl = ($urandom_range(0, 99) < 20);
            br  = ($urandom_range(0, 99) < 8);
            irq = ($urandom_range(0, 99) < 10);
            tgt = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                               : 32'($urandom_range(0, 1023));
            step(rst, stl, br, tgt, irq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
